// File: rtl/mul_iter_pkg.sv
// -----------------------------------------------------------------------------
// mul_iter_pkg
// Shared definitions for the iterative multiply / multiply-accumulate unit:
// controller state encoding and the default processor-level constants.
// -----------------------------------------------------------------------------
package mul_iter_pkg;

  // Default operand/result width and iteration counter width (2^ITER_W > WIDTH).
  localparam int WIDTH  = 32;
  localparam int ITER_W = 6;

  // Register-file addressing; writes aimed at the PC register are suppressed.
  localparam int REG_AW = 4;
  localparam int PC_IDX = 15;

  // Controller states: idle, shift-add iterations, one-cycle writeback.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage : mul_iter_pkg

// File: rtl/mul_iter_datapath.sv
// -----------------------------------------------------------------------------
// mul_iter_datapath
// Shift-add multiplier datapath. Holds the multiplicand, multiplier, partial
// product and iteration counter. A load captures fresh operands; each step
// conditionally adds the multiplicand, shifts both operands and counts.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset, clears all state
//   load_i       capture rm_i/rs_i and seed the product (rn_i or zero)
//   step_i       perform one shift-add iteration
//   acc_i        seed the product with rn_i on load (MLA)
//   rm_i         multiplicand
//   rs_i         multiplier
//   rn_i         accumulate addend
//   prod_sum_o   product value after the current step (valid while stepping)
//   last_o       current step is the final iteration
// -----------------------------------------------------------------------------
module mul_iter_datapath #(
  parameter int WIDTH  = mul_iter_pkg::WIDTH,
  parameter int ITER_W = mul_iter_pkg::ITER_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] rm_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rn_i,
  output logic [WIDTH-1:0] prod_sum_o,
  output logic             last_o
);

  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q,  mplr_d;
  logic [WIDTH-1:0]  prod_q,  prod_d;
  logic [ITER_W-1:0] iter_q,  iter_d;
  logic [WIDTH-1:0]  prod_sum;

  // Add the shifted multiplicand when the current multiplier LSB is set.
  // The sum is truncated to WIDTH bits: only the low half of the product
  // is kept, which is identical for signed and unsigned operands.
  assign prod_sum   = prod_q + (mplr_q[0] ? mcand_q : '0);
  assign prod_sum_o = prod_sum;
  assign last_o     = (iter_q == ITER_W'(WIDTH - 1));

  // NOTE: every next-state signal is given a default before the case logic,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    iter_d  = iter_q;
    if (load_i) begin
      mcand_d = rm_i;
      mplr_d  = rs_i;
      prod_d  = acc_i ? rn_i : '0;
      iter_d  = '0;
    end else if (step_i) begin
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      prod_d  = prod_sum;
      iter_d  = iter_q + ITER_W'(1);
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      iter_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      iter_q  <= iter_d;
    end
  end

endmodule : mul_iter_datapath

// File: rtl/mul_iter_unit.sv
// -----------------------------------------------------------------------------
// mul_iter_unit
// Iterative MUL / MLA unit. Operands are taken from the register-file read
// ports in execute; the result is returned as a register-file write request.
// One operation takes WIDTH cycles of RUN followed by one WB cycle. Stall
// freezes fetch/decode from the accepting cycle through the end of RUN.
//
// Ports:
//   CLK         clock, rising edge
//   Reset       synchronous active-high reset
//   Start       request an operation (only honoured in IDLE)
//   Accumulate  1 = MLA (Rm*Rs+Rn), 0 = MUL (Rm*Rs)
//   Rd          destination register
//   Rm, Rs, Rn  multiplicand, multiplier, addend
//   Busy        unit is not idle
//   Stall       Start while idle, or iterating
//   Done        one-cycle pulse in WB
//   MulWE       register-file write enable (suppressed for the PC)
//   MulA3       destination register of the last result
//   MulWD       last result (held until the next WB)
// -----------------------------------------------------------------------------
module mul_iter_unit #(
  parameter int WIDTH  = mul_iter_pkg::WIDTH,
  parameter int ITER_W = mul_iter_pkg::ITER_W,
  parameter int REG_AW = mul_iter_pkg::REG_AW,
  parameter int PC_IDX = mul_iter_pkg::PC_IDX
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Accumulate,
  input  logic [REG_AW-1:0] Rd,
  input  logic [WIDTH-1:0]  Rm,
  input  logic [WIDTH-1:0]  Rs,
  input  logic [WIDTH-1:0]  Rn,
  output logic              Busy,
  output logic              Stall,
  output logic              Done,
  output logic              MulWE,
  output logic [REG_AW-1:0] MulA3,
  output logic [WIDTH-1:0]  MulWD
);

  import mul_iter_pkg::*;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] a3_q;
  logic [WIDTH-1:0]  wd_q;

  logic             dp_load;
  logic             dp_step;
  logic             wb_capture;
  logic             dp_last;
  logic [WIDTH-1:0] dp_prod_sum;

  mul_iter_datapath #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) u_datapath (
    .clk_i      (CLK),
    .reset_i    (Reset),
    .load_i     (dp_load),
    .step_i     (dp_step),
    .acc_i      (Accumulate),
    .rm_i       (Rm),
    .rs_i       (Rs),
    .rn_i       (Rn),
    .prod_sum_o (dp_prod_sum),
    .last_o     (dp_last)
  );

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    wb_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          dp_load = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        dp_step = 1'b1;
        if (dp_last) begin
          // The final iteration's sum is the result; capture it into the
          // output register on the same edge that enters WB.
          wb_capture = 1'b1;
          state_d    = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    Busy  = (state_q != IDLE);
    Stall = (Start && (state_q == IDLE)) || (state_q == RUN);
    // A reset arriving during WB abandons the writeback, so the pulse is
    // masked rather than letting the register file capture on that edge.
    Done  = (state_q == WB) && !Reset;
    MulWE = Done && (rd_q != REG_AW'(PC_IDX));
  end

  assign MulA3 = a3_q;
  assign MulWD = wd_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (dp_load) begin
        rd_q <= Rd;
      end
      if (wb_capture) begin
        a3_q <= rd_q;
        wd_q <= dp_prod_sum;
      end
    end
  end

endmodule : mul_iter_unit
